yolo_axis_in_packer: RTL and testbench

YOLO_AXIS_IN_PACKER -- requirements
Module: yolo_axis_in_packer

---
 rtl/yolo_stream_pkg.sv | 27 ++
 rtl/yolo_axis_oreg.sv | 59 +++++
 rtl/yolo_axis_in_packer.sv | 180 ++++++++++++++++++
 tb/tb_yolo_axis_in_packer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_stream_pkg.sv
// Shared constants, widths and FSM state type for the YOLO input stream path.
package yolo_stream_pkg;

    localparam logic [31:0] CMD_START_C = 32'h0000_0020;
    localparam logic [31:0] CMD_IDLE    = 32'h0000_0000;

    localparam int IN_DW  = 64;
    localparam int OUT_DW = 128;
    localparam int OUT_KW = OUT_DW / 8;

    localparam logic [31:0]       CNT_SAT   = 32'hFFFF_FFF8;
    localparam logic [OUT_KW-1:0] KEEP_FULL = 16'hFFFF;
    localparam logic [OUT_KW-1:0] KEEP_HALF = 16'h00FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SINK,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [31:0] cnt_add8(input logic [31:0] c);
        return (c >= CNT_SAT) ? CNT_SAT : c + 32'd8;
    endfunction

endpackage

// File: rtl/yolo_axis_oreg.sv
// 128-bit AXI-stream output register slice; contents hold while stalled.
module yolo_axis_oreg
    import yolo_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [OUT_DW-1:0] ld_data,
    input  logic [OUT_KW-1:0] ld_keep,
    input  logic              ld_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_DW-1:0] out_data,
    output logic [OUT_KW-1:0] out_keep,
    output logic              out_last
);

    logic              valid_q, valid_d;
    logic [OUT_DW-1:0] data_q, data_d;
    logic [OUT_KW-1:0] keep_q, keep_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // The producer only loads when the slot is empty or draining.
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            keep_d  = ld_keep;
            last_d  = ld_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

endmodule

// File: rtl/yolo_axis_in_packer.sv
// Packs 64-bit mm2s beats into 128-bit YOLO stream words, one frame per arm.
// Optional length checking and SINK state: define YOLO_IN_LEN_CHECK_EN.
module yolo_axis_in_packer
    import yolo_stream_pkg::*;
#(
    parameter logic [31:0] CMD_START = CMD_START_C,
    parameter int          OUT_W     = 128
) (
    input  logic               sysclk,
    input  logic               sysrst_n,
    input  logic [31:0]        slave_lite_reg5,
    input  logic [31:0]        data_rd_len,
    input  logic [63:0]        s_axis_mm2s_tdata,
    input  logic [7:0]         s_axis_mm2s_tkeep,
    input  logic               s_axis_mm2s_tvalid,
    output logic               s_axis_mm2s_tready,
    input  logic               s_axis_mm2s_tlast,
    output logic [OUT_W-1:0]   m_axis_yolo_tdata,
    output logic [OUT_W/8-1:0] m_axis_yolo_tkeep,
    output logic               m_axis_yolo_tvalid,
    input  logic               m_axis_yolo_tready,
    output logic               m_axis_yolo_tlast,
    output logic               frame_done,
    output logic               len_err,
    output logic [31:0]        in_byte_cnt
);

    state_t            state_q, state_d;
    logic              half_q, half_d;
    logic [IN_DW-1:0]  lo_q, lo_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              in_hs;
    logic              len_hit;
    logic              beat_end;
    logic              ld;
    logic [OUT_DW-1:0] ld_data;
    logic [OUT_KW-1:0] ld_keep;
    logic              ld_last;

    assign s_axis_mm2s_tready =
        ((state_q == ST_RUN) &&
         (!m_axis_yolo_tvalid || m_axis_yolo_tready)) ||
        (state_q == ST_SINK);

    assign in_hs = s_axis_mm2s_tvalid && s_axis_mm2s_tready;

`ifdef YOLO_IN_LEN_CHECK_EN
    assign len_hit = ({1'b0, cnt_q} + 33'd8) >= {1'b0, data_rd_len};
`else
    assign len_hit = 1'b0;
`endif

    assign beat_end = s_axis_mm2s_tlast || len_hit;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ld      = 1'b0;
        ld_data = '0;
        ld_keep = '0;
        ld_last = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (slave_lite_reg5 == CMD_START) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    half_d  = 1'b0;
                    state_d = ST_RUN;
`ifdef YOLO_IN_LEN_CHECK_EN
                    if (data_rd_len == 32'd0 || data_rd_len[2:0] != 3'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    cnt_d = cnt_add8(cnt_q);
                    if (half_q) begin
                        ld      = 1'b1;
                        ld_data = {s_axis_mm2s_tdata, lo_q};
                        ld_keep = KEEP_FULL;
                        ld_last = beat_end;
                        half_d  = 1'b0;
                    end else if (beat_end) begin
                        // Odd beat count: emit the lone half, upper lane zeroed.
                        ld      = 1'b1;
                        ld_data = {{IN_DW{1'b0}}, s_axis_mm2s_tdata};
                        ld_keep = KEEP_HALF;
                        ld_last = 1'b1;
                    end else begin
                        lo_d   = s_axis_mm2s_tdata;
                        half_d = 1'b1;
                    end
                    if (beat_end) begin
                        state_d = ST_FLUSH;
`ifdef YOLO_IN_LEN_CHECK_EN
                        if (s_axis_mm2s_tlast && !len_hit) begin
                            err_d = 1'b1;
                        end
                        if (!s_axis_mm2s_tlast) begin
                            err_d   = 1'b1;
                            state_d = ST_SINK;
                        end
`endif
                    end
                end
            end
            ST_SINK: begin
                if (in_hs && s_axis_mm2s_tlast) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // The last word may already have left while sinking.
                if (!m_axis_yolo_tvalid ||
                    (m_axis_yolo_tready && m_axis_yolo_tlast)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (slave_lite_reg5 == CMD_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            state_q <= ST_IDLE;
            half_q  <= 1'b0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    yolo_axis_oreg u_oreg (
        .clk       (sysclk),
        .rst_n     (sysrst_n),
        .load      (ld),
        .ld_data   (ld_data),
        .ld_keep   (ld_keep),
        .ld_last   (ld_last),
        .out_ready (m_axis_yolo_tready),
        .out_valid (m_axis_yolo_tvalid),
        .out_data  (m_axis_yolo_tdata),
        .out_keep  (m_axis_yolo_tkeep),
        .out_last  (m_axis_yolo_tlast)
    );

    assign frame_done  = m_axis_yolo_tvalid && m_axis_yolo_tready &&
                         m_axis_yolo_tlast;
    assign in_byte_cnt = cnt_q;

`ifdef YOLO_IN_LEN_CHECK_EN
    assign len_err = err_q;
    logic unused_ok;
    assign unused_ok = ^s_axis_mm2s_tkeep;
`else
    assign len_err = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{s_axis_mm2s_tkeep, data_rd_len, err_q};
`endif

endmodule

// File: tb/tb_yolo_axis_in_packer.sv
// Directed bench for yolo_axis_in_packer; EN-only cases follow YOLO_IN_LEN_CHECK_EN.
module tb_yolo_axis_in_packer;
    import yolo_stream_pkg::*;

    logic         sysclk = 1'b0;
    logic         sysrst_n;
    logic [31:0]  reg5;
    logic [31:0]  rd_len;
    logic [63:0]  s_data;
    logic [7:0]   s_keep;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [127:0] m_data;
    logic [15:0]  m_keep;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         f_done;
    logic         l_err;
    logic [31:0]  b_cnt;

    always #5 sysclk = ~sysclk;

    yolo_axis_in_packer dut (
        .sysclk             (sysclk),
        .sysrst_n           (sysrst_n),
        .slave_lite_reg5    (reg5),
        .data_rd_len        (rd_len),
        .s_axis_mm2s_tdata  (s_data),
        .s_axis_mm2s_tkeep  (s_keep),
        .s_axis_mm2s_tvalid (s_valid),
        .s_axis_mm2s_tready (s_ready),
        .s_axis_mm2s_tlast  (s_last),
        .m_axis_yolo_tdata  (m_data),
        .m_axis_yolo_tkeep  (m_keep),
        .m_axis_yolo_tvalid (m_valid),
        .m_axis_yolo_tready (m_ready),
        .m_axis_yolo_tlast  (m_last),
        .frame_done         (f_done),
        .len_err            (l_err),
        .in_byte_cnt        (b_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] q_data[$];
    logic [15:0]  q_keep[$];
    logic         q_last[$];
    int           done_cnt = 0;
    int           in_cnt   = 0;
    int           stall_cnt = 0;
    int           stab_err = 0;
    int           bp_err   = 0;
    logic         chk_bp   = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [15:0]  prev_keep;
    logic         prev_last;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_keep.push_back(m_keep);
            q_last.push_back(m_last);
        end
        if (f_done) done_cnt++;
        if (s_valid && s_ready) in_cnt++;
        if (m_valid && !m_ready) stall_cnt++;
        if (prev_stall && (!m_valid || m_data != prev_data ||
            m_keep != prev_keep || m_last != prev_last)) stab_err++;
        if (chk_bp && m_valid && !m_ready && s_ready) bp_err++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_keep  = m_keep;
        prev_last  = m_last;
    end

    function automatic logic [63:0] beat(input logic [7:0] f, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return {8'hA5, f, 40'h0, ib};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        done_cnt  = 0;
        in_cnt    = 0;
        stall_cnt = 0;
        stab_err  = 0;
        bp_err    = 0;
    endtask

    task automatic arm(input logic [31:0] len);
        clear_mon();
        rd_len = len;
        reg5   = CMD_START_C;
        tick(1);
    endtask

    task automatic disarm();
        reg5 = CMD_IDLE;
        tick(2);
    endtask

    task automatic send(input logic [7:0] f, input int n, input int tl);
        for (int i = 1; i <= n; i++) begin
            int waited;
            logic ok;
            s_valid = 1'b1;
            s_data  = beat(f, i);
            s_last  = (i == tl);
            waited  = 0;
            ok      = 1'b0;
            while (!ok) begin
                @(negedge sysclk);
                ok = s_ready;
                @(posedge sysclk);
                #1;
                waited++;
                if (!ok && waited > 200) begin
                    check("send_timeout", 0, 1);
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            if (done_cnt > 0) break;
            tick(1);
        end
        if (k == 300) check("done_timeout", 0, 1);
        tick(2);
    endtask

    task automatic check_frame(input logic [7:0] f, input int n_used,
                               input int n_out);
        int m;
        check("n_out", q_data.size(), n_out);
        check("frame_done_cnt", done_cnt, 1);
        m = (q_data.size() < n_out) ? q_data.size() : n_out;
        for (int k = 0; k < m; k++) begin
            logic [127:0] ed;
            logic [15:0]  ek;
            logic         full;
            full = (2 * k + 2) <= n_used;
            ed = {full ? beat(f, 2 * k + 2) : 64'h0, beat(f, 2 * k + 1)};
            ek = full ? 16'hFFFF : 16'h00FF;
            check($sformatf("data%0d", k), q_data[k], ed);
            check($sformatf("keep%0d", k), q_keep[k], ek);
            check($sformatf("last%0d", k), q_last[k], k == n_out - 1);
        end
    endtask

    initial begin
        sysrst_n = 1'b0;
        reg5     = '0;
        rd_len   = '0;
        s_data   = '0;
        s_keep   = 8'hFF;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        m_ready  = 1'b1;
        tick(2);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_cnt", b_cnt, 0);
        check("rst_data", m_data, 0);
        check("rst_err", l_err, 0);
        sysrst_n = 1'b1;
        tick(2);

        // 8 beats into 4 full words
        arm(64);
        send(8'h01, 8, 8);
        wait_done();
        check_frame(8'h01, 8, 4);
        check("a_err", l_err, 0);
        check("a_cnt", b_cnt, 64);
        disarm();

        // odd beat count; command dropped mid-frame must be ignored
        arm(40);
        reg5 = CMD_IDLE;
        send(8'h02, 5, 5);
        wait_done();
        check_frame(8'h02, 5, 3);
        check("b_cnt", b_cnt, 40);
        check("b_err", l_err, 0);
        disarm();

        // downstream stall for 10 cycles mid-frame
        arm(64);
        chk_bp = 1'b1;
        fork
            send(8'h03, 8, 8);
            begin
                tick(3);
                m_ready = 1'b0;
                tick(10);
                m_ready = 1'b1;
            end
        join
        wait_done();
        chk_bp = 1'b0;
        check_frame(8'h03, 8, 4);
        check("c_stalled", stall_cnt >= 8, 1);
        check("c_stable", stab_err, 0);
        check("c_backpressure", bp_err, 0);
        check("c_in_cnt", in_cnt, 8);
        disarm();

`ifdef YOLO_IN_LEN_CHECK_EN
        // length reached without tlast: sink the remainder
        arm(32);
        send(8'h04, 6, 6);
        wait_done();
        check_frame(8'h04, 4, 2);
        check("d_err", l_err, 1);
        check("d_in_cnt", in_cnt, 6);
        check("d_sunk", in_cnt - 4, 2);
        check("d_cnt", b_cnt, 32);
        disarm();

        // early upstream tlast
        arm(64);
        send(8'h05, 4, 4);
        wait_done();
        check_frame(8'h05, 4, 2);
        check("e_err", l_err, 1);
        disarm();

        // misaligned length: no output, straight to DONE
        arm(12);
        tick(3);
        check("f_n_out", q_data.size(), 0);
        check("f_err", l_err, 1);
        check("f_s_ready", s_ready, 0);
        disarm();
`endif

        // reset mid-frame, then a fresh frame
        arm(64);
        send(8'h06, 3, 0);
        sysrst_n = 1'b0;
        clear_mon();
        #1;
        check("r_m_valid", m_valid, 0);
        check("r_m_data", m_data, 0);
        check("r_m_keep", m_keep, 0);
        check("r_m_last", m_last, 0);
        check("r_s_ready", s_ready, 0);
        check("r_done", f_done, 0);
        check("r_err", l_err, 0);
        check("r_cnt", b_cnt, 0);
        reg5 = CMD_IDLE;
        tick(2);
        sysrst_n = 1'b1;
        tick(3);
        check("r_no_partial", q_data.size(), 0);
        arm(32);
        send(8'h07, 4, 4);
        wait_done();
        check_frame(8'h07, 4, 2);
        check("r2_err", l_err, 0);
        check("r2_cnt", b_cnt, 32);
        disarm();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
